eq_sat_stage: RTL
=================

Name: eq_sat_stage

Overview:
Stereo output-conditioning stage between the tri-band equalizer outputs and the I2S transmitter.
- Accepts one 32-bit signed L/R sample pair per frame via valid/ready.
- Scales it by an arithmetic right shift and saturates it to OW-bit signed.
- Presents it left-justified in DW bits to the transmitter.
- Also produces per-channel clip-hold flags, decaying peak meters and a clipped-frame counter for front-panel display.

Parameters:
DW, 32, input/output sample container width (bits)
OW, 24, saturated sample width (bits), OW <= DW
IN_SHIFT, 0, arithmetic right shift applied before saturation, 0..DW-2
CLIP_HOLD, 4096, number of accepted frames a clip flag stays asserted after the last clip, >= 1
PEAK_DECAY_SHIFT, 4, peak meter decay: peak -= peak >> PEAK_DECAY_SHIFT per non-exceeding frame

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
in_valid  in  1  input pair valid
in_ready  out  1  stage can accept a pair this cycle
in_data_l  in  DW  left sample, signed
in_data_r  in  DW  right sample, signed
out_valid  out  1  output pair valid
out_ready  in  1  downstream accepts pair
out_data_l  out  DW  saturated left, signed, left-justified (sat << (DW-OW)), low DW-OW bits zero
out_data_r  out  DW  saturated right, same format
clip_l  out  1  left clip-hold flag
clip_r  out  1  right clip-hold flag
peak_l  out  OW-1  left peak magnitude, unsigned
peak_r  out  OW-1  right peak magnitude, unsigned
clip_cnt  out  16  count of accepted frames with any clip, saturating

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data_l/r=0, clip_l/r=0, peak_l/r=0, clip_cnt=0, hold counters=0.
  - Reset mid-transfer discards the held pair; no partial state survives.
- Single-register pipeline:
  - in_ready = !out_valid || out_ready (combinational). in_ready is 0 whenever rst is asserted.
  - Accept = in_valid && in_ready. On accept, the output register loads next edge and out_valid=1. Latency 1 cycle.
  - If out_valid && out_ready && !accept: out_valid<=0.
  - Simultaneous drain and accept: register replaced, out_valid stays 1. Full throughput, one pair per cycle.
  - Data held stable while out_valid && !out_ready.
- Arithmetic per channel:
  - s = x >>> IN_SHIFT, computed in DW+1 bits.
  - MAX = 2^(OW-1)-1, MIN = -2^(OW-1).
  - If s > MAX, result = MAX and clip=1. If s < MIN, result = MIN and clip=1. Otherwise result = s.
  - Exact boundary values MAX and MIN are not clips.
- Magnitude: mag = |result|, with |MIN| clamped to MAX, width OW-1.
- Peak update, on accept only:
  - If mag > peak: peak <= mag.
  - Else: peak <= peak - (peak >> PEAK_DECAY_SHIFT). peak never underflows; once below 2^PEAK_DECAY_SHIFT it holds.
  - Peak is updated in the same edge as the output register.
- Clip hold, per channel, on accept only:
  - If the channel clipped: hold <= CLIP_HOLD.
  - Else if hold != 0: hold <= hold - 1.
  - clip_x = (hold != 0), registered.
  - Counter width is $clog2(CLIP_HOLD+1).
  - No decrement while stalled (no accept).
- clip_cnt: +1 on each accept where either channel clipped; sticks at 16'hFFFF.
- Meters and flags advance only on accepted frames, never on idle or stall cycles.

Optional Feature:
Macro EQ_SAT_ROUND_EN.
- Defined and IN_SHIFT > 0: before the shift, add 2^(IN_SHIFT-1) in DW+1 bits, i.e. round half toward +inf. The widened add prevents wrap, so 0x7FFFFFFF rounds up then saturates.
- Not defined, or IN_SHIFT = 0: plain arithmetic shift (floor).
- All other behaviour is identical.

Test Plan:
- Reset then pass-through (IN_SHIFT=0, OW=24): in_l=0x00001234, out_ready=1.
  - Response: next cycle out_valid=1, out_data_l=0x00123400, clip_l=0, peak_l=0x1234, clip_cnt=0.
- Saturation boundaries: in_l=0x007FFFFF, then 0x00800000, then 0xFF800000, then 0xFF7FFFFF.
  - out_data_l = 0x7FFFFF00, 0x7FFFFF00, 0x80000000, 0x80000000.
  - clip_cnt ends at 2; clip_l asserted after the 2nd pair.
- Backpressure: out_ready=0 with 3 pairs offered.
  - Only the first is accepted; in_ready=0 and out_data is stable.
  - Raise out_ready: the remaining pairs follow one per cycle with no loss or duplication.
  - Peak and clip hold do not change during the stall.
- Clip hold (CLIP_HOLD=4): one clipped frame, then 5 clean accepted frames.
  - clip_l is high through the 4th clean frame and low after the 5th; 100 idle cycles change nothing.
- Peak decay (PEAK_DECAY_SHIFT=4): one frame with mag 0x1000, then zero frames.
  - peak_l sequence: 0x1000, 0x0F00, 0x0E10, ...
  - A larger input mid-decay jumps peak_l immediately.
- Rounding (IN_SHIFT=4): in_l=0x00000018.
  - With EQ_SAT_ROUND_EN: out=0x00000200.
  - Without: out=0x00000100.
  - Assert rst with out_valid=1 and out_ready=0: out_valid=0 and all meters are 0 the next cycle.

Source files
------------

// File: rtl/eq_sat_stage.sv
// eq_sat_stage: stereo output conditioning between the equalizer and the I2S
// transmitter. Each accepted L/R pair is arithmetically shifted, saturated to
// OW-bit signed and presented left-justified in DW bits through a single
// valid/ready register slice. The stage also keeps per-channel clip-hold
// flags, decaying peak meters and a saturating clipped-frame counter.
//
// Optional feature: define EQ_SAT_ROUND_EN to round half toward +inf before
// the shift (only has an effect when IN_SHIFT > 0). The default build floors.
module eq_sat_stage #(
    parameter int DW               = 32,
    parameter int OW               = 24,
    parameter int IN_SHIFT         = 0,
    parameter int CLIP_HOLD        = 4096,
    parameter int PEAK_DECAY_SHIFT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data_l,
    input  logic [DW-1:0] in_data_r,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data_l,
    output logic [DW-1:0] out_data_r,
    output logic          clip_l,
    output logic          clip_r,
    output logic [OW-2:0] peak_l,
    output logic [OW-2:0] peak_r,
    output logic [15:0]   clip_cnt
);

    localparam int HW = $clog2(CLIP_HOLD + 1);

    // Saturation limits held in the widened DW+1 domain so comparisons are exact.
    localparam logic signed [DW:0] MAXV = (DW+1)'((64'sd1 <<< (OW - 1)) - 64'sd1);
    localparam logic signed [DW:0] MINV = ~MAXV;

`ifdef EQ_SAT_ROUND_EN
    // Half an LSB of the shifted result; zero when there is no shift.
    localparam int RSH = (IN_SHIFT > 0) ? IN_SHIFT - 1 : 0;
    localparam logic [DW:0] RND = (IN_SHIFT > 0) ? ((DW+1)'(1) << RSH) : '0;
`endif

    logic          accept;
    logic          out_valid_q, out_valid_d;
    logic [15:0]   cnt_q, cnt_d;

    logic [DW-1:0] din      [2];
    logic [DW-1:0] dout     [2];
    logic [OW-2:0] peak_o   [2];
    logic          flag_o   [2];
    logic          clip_now [2];

    assign din[0] = in_data_l;
    assign din[1] = in_data_r;

    // A pair can be taken when the slice is empty or draining this cycle.
    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic signed [DW:0] ext_c;
            logic signed [DW:0] s_c;
            logic [OW-1:0]      res_c;
            logic [OW-2:0]      mag_c;
            logic               clip_c;
            logic [DW-1:0]      data_q, data_d;
            logic [OW-2:0]      peak_q, peak_d;
            logic [HW-1:0]      hold_q, hold_d;
            logic               flag_q, flag_d;

            // Scale, saturate and take the clamped magnitude of one channel.
            always_comb begin
                ext_c = {din[gi][DW-1], din[gi]};
`ifdef EQ_SAT_ROUND_EN
                ext_c = ext_c + RND;
`endif
                s_c    = ext_c >>> IN_SHIFT;
                clip_c = 1'b1;
                if (s_c > MAXV) begin
                    res_c = MAXV[OW-1:0];
                end else if (s_c < MINV) begin
                    res_c = MINV[OW-1:0];
                end else begin
                    res_c  = s_c[OW-1:0];
                    clip_c = 1'b0;
                end
                // |MIN| does not fit in OW-1 bits, so it reads as full scale.
                if (!res_c[OW-1]) begin
                    mag_c = res_c[OW-2:0];
                end else if (res_c[OW-2:0] == '0) begin
                    mag_c = '1;
                end else begin
                    mag_c = ~res_c[OW-2:0] + (OW-1)'(1);
                end
            end

            // Output word, peak meter and clip hold advance only on accepted frames.
            always_comb begin
                data_d = data_q;
                peak_d = peak_q;
                hold_d = hold_q;
                flag_d = flag_q;
                if (accept) begin
                    data_d = DW'(res_c) << (DW - OW);
                    if (mag_c > peak_q) begin
                        peak_d = mag_c;
                    end else begin
                        peak_d = peak_q - (peak_q >> PEAK_DECAY_SHIFT);
                    end
                    if (clip_c) begin
                        hold_d = HW'(CLIP_HOLD);
                    end else if (hold_q != '0) begin
                        hold_d = hold_q - HW'(1);
                    end
                    // Flag reflects the hold state before this frame's decrement,
                    // so it covers the clipped frame plus CLIP_HOLD clean frames.
                    flag_d = clip_c || (hold_q != '0);
                end
            end

            // Per-channel state registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                    peak_q <= '0;
                    hold_q <= '0;
                    flag_q <= 1'b0;
                end else begin
                    data_q <= data_d;
                    peak_q <= peak_d;
                    hold_q <= hold_d;
                    flag_q <= flag_d;
                end
            end

            assign dout[gi]     = data_q;
            assign peak_o[gi]   = peak_q;
            assign flag_o[gi]   = flag_q;
            assign clip_now[gi] = clip_c;
        end
    endgenerate

    // Slice occupancy and the saturating count of frames with any clip.
    always_comb begin
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        cnt_d = cnt_q;
        if (accept && (clip_now[0] || clip_now[1]) && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Shared state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data_l = dout[0];
    assign out_data_r = dout[1];
    assign clip_l     = flag_o[0];
    assign clip_r     = flag_o[1];
    assign peak_l     = peak_o[0];
    assign peak_r     = peak_o[1];
    assign clip_cnt   = cnt_q;

endmodule
